// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_IV   = 2'd3
  } owner_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so MEM_LAT=1 still gets a 1-bit counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arb_pri_sel.sv
// Combinational winner picker: IV first, then DM over IF unless IF is promoted.
module mem_arb_pri_sel
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       iv_req,
  input  logic       promote_if,
  output logic [1:0] sel
);

  always_comb begin
    sel = OWN_NONE;
    if (iv_req)                    sel = OWN_IV;
    else if (promote_if && if_req) sel = OWN_IF;
    else if (dm_req)               sel = OWN_DM;
    else if (if_req)               sel = OWN_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between fetch, data and vector requesters,
// one fixed-latency access at a time, with starvation promotion for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  input  logic          iv_req,
  input  logic [AW-1:0] iv_addr,
  output logic          iv_ack,
  output logic [DW-1:0] iv_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int CW = clog2(MEM_LAT);
  localparam int SW = clog2(STARVE_LIM + 1);

  state_t        state_reg;
  owner_t        owner_reg;
  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] starve_reg;
  logic          flush_pend_reg;
  logic          mem_en_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;

  logic [1:0]    winner;
  logic [AW-1:0] win_addr;
  logic          any_req;
  logic          promote_if;
  logic          last_cycle;

  assign any_req    = if_req | dm_req | iv_req;
  assign promote_if = (starve_reg == SW'(STARVE_LIM));
  assign last_cycle = (state_reg == ST_ACCESS) && (cnt_reg == CW'(MEM_LAT - 1));

  mem_arb_pri_sel u_pri_sel (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .iv_req     (iv_req),
    .promote_if (promote_if),
    .sel        (winner)
  );

  always_comb begin
    win_addr = if_addr;
    if (winner == OWN_DM)      win_addr = dm_addr;
    else if (winner == OWN_IV) win_addr = iv_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_NONE;
      cnt_reg        <= '0;
      starve_reg     <= '0;
      flush_pend_reg <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      // Fetch starvation counter: only DM grants that jump a waiting fetch count.
      if (!if_req) begin
        starve_reg <= '0;
      end else if (state_reg == ST_IDLE && any_req) begin
        if (winner == OWN_IF)
          starve_reg <= '0;
        else if (winner == OWN_DM && !promote_if)
          starve_reg <= starve_reg + 1'b1;
      end

      if (state_reg == ST_IDLE) begin
        if (any_req) begin
          state_reg     <= ST_ACCESS;
          owner_reg     <= owner_t'(winner);
          cnt_reg       <= '0;
          mem_en_reg    <= 1'b1;
          mem_we_reg    <= (winner == OWN_DM) && dm_we;
          mem_addr_reg  <= win_addr;
          mem_wdata_reg <= (winner == OWN_DM) ? dm_wdata : '0;
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        if (if_flush && owner_reg == OWN_IF)
          flush_pend_reg <= 1'b1;
        if (last_cycle) begin
          state_reg      <= ST_IDLE;
          owner_reg      <= OWN_NONE;
          cnt_reg        <= '0;
          mem_en_reg     <= 1'b0;
          mem_we_reg     <= 1'b0;
          flush_pend_reg <= 1'b0;
        end
      end
    end
  end

  // A flush seen earlier in the access or in the completing cycle kills the fetch ack.
  assign if_ack   = last_cycle && (owner_reg == OWN_IF) && !flush_pend_reg && !if_flush;
  assign dm_ack   = last_cycle && (owner_reg == OWN_DM);
  assign iv_ack   = last_cycle && (owner_reg == OWN_IV);
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign dm_rdata = dm_ack ? mem_rdata : '0;
  assign iv_rdata = iv_ack ? mem_rdata : '0;
  assign if_stall = if_req & ~if_ack;

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner     = owner_reg;

endmodule
